// File: rtl/trackball_quad_gen.sv
// Trackball emulation: accumulates mouse deltas and joystick directions per axis and
// drains them as two-axis Gray-coded quadrature phases, at most one edge per step tick.
module trackball_quad_gen #(
  parameter int STEP_DIV = 1600,
  parameter int ACC_W    = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       delta_stb,
  input  logic [8:0] dx,
  input  logic [8:0] dy,
  input  logic       joy_l,
  input  logic       joy_r,
  input  logic       joy_u,
  input  logic       joy_d,
  input  logic       inv_x,
  input  logic       inv_y,
  output logic       quad_xa,
  output logic       quad_xb,
  output logic       quad_ya,
  output logic       quad_yb,
  output logic [7:0] pos_x,
  output logic [7:0] pos_y,
  output logic       busy
);

  localparam int DIV_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  // Wide enough for acc +/- a full 9-bit delta (including +256) plus one drain step.
  localparam int SUM_W = ((ACC_W > 10) ? ACC_W : 10) + 2;
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'(2 ** (ACC_W - 1) - 1);

  function automatic logic [1:0] quad_of(input logic [1:0] p);
    case (p)
      2'd0:    quad_of = 2'b00;
      2'd1:    quad_of = 2'b10;
      2'd2:    quad_of = 2'b11;
      default: quad_of = 2'b01;
    endcase
  endfunction

  logic [DIV_W-1:0] div_reg;
  logic             tick;
  logic             busy_reg;
  logic [1:0]       nz_next;

  assign tick = (div_reg == DIV_W'(STEP_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_reg  <= '0;
      busy_reg <= 1'b0;
    end else begin
      div_reg  <= tick ? '0 : div_reg + DIV_W'(1);
      busy_reg <= |nz_next;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : axis
    logic [8:0]              d_in;
    logic                    inv, jp, jm;
    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic signed [SUM_W-1:0] delta_ext, delta_term, drain, sum;
    logic                    acc_pos, acc_neg, step_up, step_dn;
    logic [1:0]              phase_reg, phase_next, quad_reg;
    logic [7:0]              pos_reg, pos_next;

    assign d_in = (gi == 0) ? dx : dy;
    assign inv  = (gi == 0) ? inv_x : inv_y;
    assign jp   = (gi == 0) ? joy_r : joy_d;
    assign jm   = (gi == 0) ? joy_l : joy_u;

    always_comb begin
      delta_ext  = SUM_W'($signed(d_in));
      delta_term = '0;
      if (delta_stb) delta_term = inv ? -delta_ext : delta_ext;
      acc_pos = ~acc_reg[ACC_W-1] & (|acc_reg);
      acc_neg = acc_reg[ACC_W-1];

      // Pending count has priority; the joystick only steps an idle axis.
      step_up = 1'b0;
      step_dn = 1'b0;
      if (tick) begin
        if (acc_pos) step_up = 1'b1;
        else if (acc_neg) step_dn = 1'b1;
        else if (jp & ~jm) begin
          step_up = ~inv;
          step_dn = inv;
        end else if (jm & ~jp) begin
          step_up = inv;
          step_dn = ~inv;
        end
      end

      drain = '0;
      if (tick & acc_pos) drain = SUM_W'(1);
      else if (tick & acc_neg) drain = {SUM_W{1'b1}};
      sum = SUM_W'(acc_reg) + delta_term - drain;

      if (sum > ACC_MAX) acc_next = ACC_W'(ACC_MAX);
      else if (sum < -ACC_MAX) acc_next = ACC_W'(-ACC_MAX);
      else acc_next = ACC_W'(sum);

      phase_next = phase_reg;
      pos_next   = pos_reg;
      if (step_up) begin
        phase_next = phase_reg + 2'd1;
        pos_next   = pos_reg + 8'd1;
      end else if (step_dn) begin
        phase_next = phase_reg - 2'd1;
        pos_next   = pos_reg - 8'd1;
      end
    end

    assign nz_next[gi] = |acc_next;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        acc_reg   <= '0;
        phase_reg <= 2'd0;
        quad_reg  <= 2'b00;
        pos_reg   <= 8'd0;
      end else begin
        acc_reg   <= acc_next;
        phase_reg <= phase_next;
        quad_reg  <= quad_of(phase_next);
        pos_reg   <= pos_next;
      end
    end
  end

  assign quad_xa = axis[0].quad_reg[1];
  assign quad_xb = axis[0].quad_reg[0];
  assign quad_ya = axis[1].quad_reg[1];
  assign quad_yb = axis[1].quad_reg[0];
  assign pos_x   = axis[0].pos_reg;
  assign pos_y   = axis[1].pos_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_trackball_quad_gen.sv
// Self-checking bench for trackball_quad_gen: integer reference model compared every cycle,
// a table of delta vectors, and hand sequences for reset, saturation, joystick and overlap.
module tb_trackball_quad_gen;
  localparam int SD   = 4;
  localparam int AW   = 10;
  localparam int AMAX = 511;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              delta_stb = 1'b0;
  logic signed [8:0] dx = '0;
  logic signed [8:0] dy = '0;
  logic joy_l = 0, joy_r = 0, joy_u = 0, joy_d = 0, inv_x = 0, inv_y = 0;
  logic quad_xa, quad_xb, quad_ya, quad_yb, busy;
  logic [7:0] pos_x, pos_y;

  trackball_quad_gen #(.STEP_DIV(SD), .ACC_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .delta_stb(delta_stb), .dx(dx), .dy(dy),
    .joy_l(joy_l), .joy_r(joy_r), .joy_u(joy_u), .joy_d(joy_d),
    .inv_x(inv_x), .inv_y(inv_y),
    .quad_xa(quad_xa), .quad_xb(quad_xb), .quad_ya(quad_ya), .quad_yb(quad_yb),
    .pos_x(pos_x), .pos_y(pos_y), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: signed integer counts, phase and position as plain modular arithmetic.
  int m_div = 0;
  int m_acc[2] = '{0, 0};
  int m_ph[2]  = '{0, 0};
  int m_pos[2] = '{0, 0};
  bit m_busy = 0;

  function automatic int clampi(int v);
    if (v > AMAX) return AMAX;
    if (v < -AMAX) return -AMAX;
    return v;
  endfunction

  function automatic logic [1:0] qmap(int p);
    case (p)
      0: return 2'b00;
      1: return 2'b10;
      2: return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    int tk, d, s, drain, jv;
    if (!reset_n) begin
      m_div = 0;
      for (int a = 0; a < 2; a++) begin
        m_acc[a] = 0; m_ph[a] = 0; m_pos[a] = 0;
      end
      m_busy = 0;
    end else begin
      tk = (m_div == SD - 1) ? 1 : 0;
      m_div = tk ? 0 : m_div + 1;
      for (int a = 0; a < 2; a++) begin
        d = 0;
        if (delta_stb) begin
          d = (a == 0) ? int'(dx) : int'(dy);
          if ((a == 0) ? inv_x : inv_y) d = -d;
        end
        s = 0; drain = 0;
        if (tk != 0) begin
          if (m_acc[a] > 0) begin s = 1; drain = 1; end
          else if (m_acc[a] < 0) begin s = -1; drain = -1; end
          else begin
            jv = (a == 0) ? (int'(joy_r) - int'(joy_l)) : (int'(joy_d) - int'(joy_u));
            if ((a == 0) ? inv_x : inv_y) jv = -jv;
            s = jv;
          end
        end
        m_acc[a] = clampi(m_acc[a] - drain + d);
        m_ph[a]  = (m_ph[a] + s + 4) % 4;
        m_pos[a] = (m_pos[a] + s + 256) % 256;
      end
      m_busy = (m_acc[0] != 0) || (m_acc[1] != 0);
    end
  end

  int checks = 0;
  int errors = 0;
  int edges_x = 0;
  logic [1:0] prev_x = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // One cycle: wait for the falling edge, compare all outputs with the model, count X edges.
  task automatic step();
    logic [22:0] act, exp;
    @(negedge clk);
    act = {quad_xa, quad_xb, quad_ya, quad_yb, pos_x, pos_y, busy};
    exp = {qmap(m_ph[0]), qmap(m_ph[1]), 8'(m_pos[0]), 8'(m_pos[1]), m_busy};
    check("cycle_model", 32'(act), 32'(exp));
    if ({quad_xa, quad_xb} != prev_x) edges_x++;
    prev_x = {quad_xa, quad_xb};
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input int vx, input int vy);
    delta_stb = 1'b1; dx = 9'(vx); dy = 9'(vy);
    step();
    delta_stb = 1'b0; dx = '0; dy = '0;
  endtask

  // Leaves the bench at a falling edge where the next rising edge is a tick.
  task automatic wait_pre_tick();
    int n;
    n = 0;
    while (m_div != SD - 1 && n < 2 * SD) begin
      step();
      n++;
    end
    if (m_div != SD - 1) begin
      errors++;
      $display("FAIL align_timeout actual=%0d required=%0d", m_div, SD - 1);
    end
  endtask

  typedef struct {
    int dx; int dy; bit ix; bit iy; int epx; int epy;
  } vec_t;
  vec_t tbl[6];

  function automatic int mod256(int v);
    return ((v % 256) + 256) % 256;
  endfunction

  int exp_px, exp_py, e0, n;

  initial begin
    tbl[0] = '{3, 0, 1'b0, 1'b0, 3, 0};
    tbl[1] = '{0, -2, 1'b0, 1'b1, 0, 2};
    tbl[2] = '{-5, 4, 1'b0, 1'b0, -5, 4};
    tbl[3] = '{7, -3, 1'b1, 1'b1, -7, 3};
    tbl[4] = '{-256, 0, 1'b0, 1'b0, -256, 0};
    tbl[5] = '{-256, 17, 1'b1, 1'b0, 256, 17};

    // Reset held with strobes pulsing: every output stays at zero.
    for (int i = 0; i < 6; i++) begin
      delta_stb = i[0]; dx = 9'(5); dy = 9'(-3);
      @(negedge clk);
      check("reset_out", 32'({quad_xa, quad_xb, quad_ya, quad_yb, pos_x, pos_y, busy}), 32'd0);
    end
    delta_stb = 1'b0; dx = '0; dy = '0;
    reset_n = 1'b1;
    joy_r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("pre_first_tick", 32'({quad_xa, quad_xb}), 32'd0);
    end
    step();
    check("first_tick_quad", 32'({quad_xa, quad_xb}), 32'b10);
    check("first_tick_pos", 32'(pos_x), 32'd1);
    joy_r = 1'b0;
    $display("reset/first tick: pos_x=%0d quad_x=%b%b", pos_x, quad_xa, quad_xb);
    exp_px = 1; exp_py = 0;

    // Table of delta vectors, each drained completely before the result is compared.
    for (int i = 0; i < 6; i++) begin
      inv_x = tbl[i].ix; inv_y = tbl[i].iy;
      pulse(tbl[i].dx, tbl[i].dy);
      n = (tbl[i].dx < 0) ? -tbl[i].dx : tbl[i].dx;
      if (tbl[i].dy > n) n = tbl[i].dy;
      if (-tbl[i].dy > n) n = -tbl[i].dy;
      cycles((n + 2) * SD);
      inv_x = 1'b0; inv_y = 1'b0;
      exp_px = mod256(exp_px + tbl[i].epx);
      exp_py = mod256(exp_py + tbl[i].epy);
      check("vec_pos_x", 32'(pos_x), 32'(exp_px));
      check("vec_pos_y", 32'(pos_y), 32'(exp_py));
      check("vec_quad_x", 32'({quad_xa, quad_xb}), 32'(qmap(exp_px % 4)));
      check("vec_quad_y", 32'({quad_ya, quad_yb}), 32'(qmap(exp_py % 4)));
      check("vec_busy", 32'(busy), 32'd0);
      $display("vec %0d dx=%0d dy=%0d inv=%b%b pos_x=%0d pos_y=%0d", i, tbl[i].dx, tbl[i].dy,
               tbl[i].ix, tbl[i].iy, pos_x, pos_y);
    end

    // Saturation: four +255 strobes, the first on a tick with acc idle -> 511 edges.
    wait_pre_tick();
    e0 = edges_x;
    for (int i = 0; i < 4; i++) pulse(255, 0);
    check("sat_busy", 32'(busy), 32'd1);
    cycles(520 * SD);
    check("sat_edges", 32'(edges_x - e0), 32'd511);
    check("sat_busy_end", 32'(busy), 32'd0);
    exp_px = mod256(exp_px + 511);
    check("sat_pos_x", 32'(pos_x), 32'(exp_px));
    $display("saturation: edges=%0d pos_x=%0d", edges_x - e0, pos_x);

    // Joystick on an idle axis: one step per tick; opposing directions cancel.
    wait_pre_tick();
    joy_r = 1'b1;
    cycles(5 * SD);
    exp_px = mod256(exp_px + 5);
    check("joy_r_pos", 32'(pos_x), 32'(exp_px));
    joy_l = 1'b1;
    cycles(5 * SD);
    check("joy_lr_pos", 32'(pos_x), 32'(exp_px));
    joy_l = 1'b0; joy_r = 1'b0;
    joy_u = 1'b1; inv_y = 1'b1;
    cycles(3 * SD);
    exp_py = mod256(exp_py + 3);
    check("joy_u_inv_pos", 32'(pos_y), 32'(exp_py));
    joy_u = 1'b0; inv_y = 1'b0;
    $display("joystick: pos_x=%0d pos_y=%0d", pos_x, pos_y);

    // Strobe on the tick cycle while acc=1: one edge emitted, acc stays 1.
    wait_pre_tick();
    step();
    pulse(1, 0);
    wait_pre_tick();
    e0 = edges_x;
    pulse(1, 0);
    check("overlap_edge", 32'(edges_x - e0), 32'd1);
    check("overlap_busy", 32'(busy), 32'd1);
    cycles(2 * SD);
    check("overlap_edges2", 32'(edges_x - e0), 32'd2);
    check("overlap_busy_end", 32'(busy), 32'd0);
    exp_px = mod256(exp_px + 2);
    check("overlap_pos", 32'(pos_x), 32'(exp_px));
    $display("overlap: edges=%0d pos_x=%0d", edges_x - e0, pos_x);

    // Reset mid-drain clears outputs immediately and discards the pending count.
    pulse(50, 0);
    cycles(10 * SD);
    check("mid_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1 check("async_clear", 32'({quad_xa, quad_xb, quad_ya, quad_yb, pos_x, pos_y, busy}), 32'd0);
    cycles(3);
    reset_n = 1'b1;
    step();
    e0 = edges_x;
    cycles(30 * SD);
    check("post_reset_edges", 32'(edges_x - e0), 32'd0);
    check("post_reset_pos", 32'(pos_x), 32'd0);
    check("post_reset_busy", 32'(busy), 32'd0);
    $display("mid-drain reset: pos_x=%0d busy=%0d", pos_x, busy);

    // Randomized traffic, compared against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      delta_stb = ($urandom_range(0, 5) == 0);
      dx = 9'($urandom);
      dy = 9'($urandom);
      if ($urandom_range(0, 49) == 0) inv_x = ~inv_x;
      if ($urandom_range(0, 49) == 0) inv_y = ~inv_y;
      if ($urandom_range(0, 19) == 0) {joy_l, joy_r, joy_u, joy_d} = 4'($urandom);
      step();
    end
    delta_stb = 1'b0;
    $display("random: 3000 cycles, pos_x=%0d pos_y=%0d", pos_x, pos_y);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
